// File: rtl/ppu_pkg.sv
// ppu_pkg: shared encodings for the PPU hazard controller
package ppu_pkg;
  localparam int REG_W = 5;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b11;
  localparam logic NOP_SEL = 1'b1;
  typedef enum logic {ST_RUN, ST_MD_BUSY} md_state_t;
endpackage

// File: rtl/md_busy_tracker.sv
// md_busy_tracker: occupancy counter and FSM for the multi-cycle HI/LO mult/div unit
module md_busy_tracker #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic accept,
  output logic md_busy
);
  import ppu_pkg::*;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MD_LATENCY);
  md_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (state == ST_RUN) begin
      state_nxt = accept ? ST_MD_BUSY : ST_RUN;
      cnt_nxt = accept ? LAT : '0;
    end else begin
      state_nxt = (cnt == CNT_W'(1)) ? ST_RUN : ST_MD_BUSY;
      cnt_nxt = cnt - CNT_W'(1);
    end
  end
  assign md_busy = cnt != '0;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PPU load enables, NOP injection, forwarding selects and mult/div interlock
// HAZARD_STATS_EN adds saturating stall_cycles / bubble_md counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W = ppu_pkg::REG_W,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic id_uses_rs,
  input  logic id_uses_rt,
  input  logic id_is_md,
  input  logic id_is_mfhilo,
  input  logic [REG_W-1:0] ex_rd,
  input  logic ex_rf_enable,
  input  logic ex_load_instr,
  input  logic [REG_W-1:0] mem_rd,
  input  logic mem_rf_enable,
  input  logic [REG_W-1:0] wb_rd,
  input  logic wb_rf_enable,
  output logic pc_ld,
  output logic npc_ld,
  output logic ifid_ld,
  output logic cu_mux_s,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] bubble_md
`endif
);
  import ppu_pkg::*;
  logic busy, load_use, md_hazard, stall, ex_fwd_ok;
  logic [1:0] sel_a, sel_b;
  md_busy_tracker #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) u_md (
    .clk(clk),
    .reset(reset),
    .accept(id_is_md && !stall),
    .md_busy(busy)
  );
  assign ex_fwd_ok = ex_rf_enable && !ex_load_instr;
  always_comb begin
    sel_a = (!id_uses_rs || id_rs == '0) ? FWD_RF :
            (ex_fwd_ok && ex_rd == id_rs) ? FWD_EX :
            (mem_rf_enable && mem_rd == id_rs) ? FWD_MEM :
            (wb_rf_enable && wb_rd == id_rs) ? FWD_WB : FWD_RF;
    sel_b = (!id_uses_rt || id_rt == '0) ? FWD_RF :
            (ex_fwd_ok && ex_rd == id_rt) ? FWD_EX :
            (mem_rf_enable && mem_rd == id_rt) ? FWD_MEM :
            (wb_rf_enable && wb_rd == id_rt) ? FWD_WB : FWD_RF;
  end
  assign load_use = ex_load_instr && ex_rf_enable && ex_rd != '0 &&
                    ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  assign md_busy = reset && busy;
  assign md_hazard = md_busy && (id_is_md || id_is_mfhilo);
  assign stall = load_use || md_hazard;
  assign pc_ld = reset && !stall;
  assign npc_ld = pc_ld;
  assign ifid_ld = pc_ld;
  assign cu_mux_s = (!reset || stall) ? NOP_SEL : ~NOP_SEL;
  assign fwd_a_sel = reset ? sel_a : FWD_RF;
  assign fwd_b_sel = reset ? sel_b : FWD_RF;
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      bubble_md <= '0;
    end else begin
      stall_cycles <= stall_cycles + 16'(stall && stall_cycles != 16'hFFFF);
      bubble_md <= bubble_md + 16'(md_hazard && !load_use && bubble_md != 16'hFFFF);
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs, id_uses_rt, id_is_md, id_is_mfhilo;
  logic ex_rf_enable, ex_load_instr, mem_rf_enable, wb_rf_enable;
  logic pc_ld, npc_ld, ifid_ld, cu_mux_s, md_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, bubble_md;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_md(id_is_md), .id_is_mfhilo(id_is_mfhilo),
    .ex_rd(ex_rd), .ex_rf_enable(ex_rf_enable), .ex_load_instr(ex_load_instr),
    .mem_rd(mem_rd), .mem_rf_enable(mem_rf_enable),
    .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
    .pc_ld(pc_ld), .npc_ld(npc_ld), .ifid_ld(ifid_ld), .cu_mux_s(cu_mux_s),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .md_busy(md_busy)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .bubble_md(bubble_md)
`endif
  );

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_is_md = 0; id_is_mfhilo = 0;
    ex_rd = 0; ex_rf_enable = 0; ex_load_instr = 0;
    mem_rd = 0; mem_rf_enable = 0; wb_rd = 0; wb_rf_enable = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    id_is_md = 1; id_rs = 4; id_uses_rs = 1; ex_rd = 4; ex_rf_enable = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({pc_ld, npc_ld, ifid_ld, cu_mux_s, md_busy} !== 5'b00010) begin
        bad++;
        $display("FAIL reset_ctl cyc=%0d got=%b exp=00010", i, {pc_ld, npc_ld, ifid_ld, cu_mux_s, md_busy});
      end
      total++;
      if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_fwd got=%b exp=0000", {fwd_a_sel, fwd_b_sel});
      end
    end
`ifdef HAZARD_STATS_EN
    total++;
    if (stall_cycles !== 16'd0 || bubble_md !== 16'd0) begin
      bad++;
      $display("FAIL reset_stats got=%0d/%0d exp=0/0", stall_cycles, bubble_md);
    end
`endif
    clear_inputs();
    reset = 1'b1;
    #1;
    total++;
    if ({pc_ld, npc_ld, ifid_ld, cu_mux_s, md_busy} !== 5'b11100) begin
      bad++;
      $display("FAIL release_ctl got=%b exp=11100", {pc_ld, npc_ld, ifid_ld, cu_mux_s, md_busy});
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_rd = 5; ex_rf_enable = 1; ex_load_instr = 1; id_rs = 5; id_uses_rs = 1;
    #1;
    total++;
    if ({pc_ld, npc_ld, ifid_ld, cu_mux_s} !== 4'b0001) begin
      bad++;
      $display("FAIL load_use_stall got=%b exp=0001", {pc_ld, npc_ld, ifid_ld, cu_mux_s});
    end
    step();
    clear_inputs();
    id_rs = 5; id_uses_rs = 1; mem_rd = 5; mem_rf_enable = 1;
    #1;
    total++;
    if ({pc_ld, cu_mux_s, fwd_a_sel} !== 4'b1010) begin
      bad++;
      $display("FAIL load_use_after got=%b exp=1010", {pc_ld, cu_mux_s, fwd_a_sel});
    end
    clear_inputs();
    ex_rd = 9; ex_rf_enable = 1; ex_load_instr = 1; id_rt = 9; id_uses_rt = 1;
    #1;
    total++;
    if ({pc_ld, cu_mux_s} !== 2'b01) begin
      bad++;
      $display("FAIL load_use_rt got=%b exp=01", {pc_ld, cu_mux_s});
    end
    id_uses_rt = 0;
    #1;
    total++;
    if ({pc_ld, cu_mux_s} !== 2'b10) begin
      bad++;
      $display("FAIL load_use_unused got=%b exp=10", {pc_ld, cu_mux_s});
    end
    ex_rd = 0; id_rt = 0; id_uses_rt = 1;
    #1;
    total++;
    if ({pc_ld, cu_mux_s} !== 2'b10) begin
      bad++;
      $display("FAIL load_use_r0 got=%b exp=10", {pc_ld, cu_mux_s});
    end
    step();
  endtask

  task automatic test_forward();
    clear_inputs();
    ex_rd = 3; ex_rf_enable = 1; mem_rd = 3; mem_rf_enable = 1; id_rt = 3; id_uses_rt = 1;
    #1;
    total++;
    if (fwd_b_sel !== 2'b01 || fwd_a_sel !== 2'b00) begin
      bad++;
      $display("FAIL fwd_ex got=%b/%b exp=00/01", fwd_a_sel, fwd_b_sel);
    end
    ex_rd = 0; mem_rd = 0; id_rt = 0;
    #1;
    total++;
    if (fwd_b_sel !== 2'b00) begin
      bad++;
      $display("FAIL fwd_r0 got=%b exp=00", fwd_b_sel);
    end
    ex_rd = 3; ex_rf_enable = 0; mem_rd = 3; id_rt = 3;
    #1;
    total++;
    if (fwd_b_sel !== 2'b10) begin
      bad++;
      $display("FAIL fwd_mem got=%b exp=10", fwd_b_sel);
    end
    clear_inputs();
    wb_rd = 12; wb_rf_enable = 1; mem_rd = 11; mem_rf_enable = 1; id_rs = 12; id_uses_rs = 1; id_rt = 11; id_uses_rt = 1;
    #1;
    total++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1110) begin
      bad++;
      $display("FAIL fwd_wb_mem got=%b exp=1110", {fwd_a_sel, fwd_b_sel});
    end
    id_uses_rs = 0; wb_rf_enable = 0;
    #1;
    total++;
    if (fwd_a_sel !== 2'b00) begin
      bad++;
      $display("FAIL fwd_unused got=%b exp=00", fwd_a_sel);
    end
    step();
  endtask

  task automatic test_md();
    int stalls = 0;
    clear_inputs();
    id_is_md = 1;
    #1;
    total++;
    if ({pc_ld, cu_mux_s, md_busy} !== 3'b100) begin
      bad++;
      $display("FAIL md_accept got=%b exp=100", {pc_ld, cu_mux_s, md_busy});
    end
    step();
    clear_inputs();
    id_uses_rs = 1; id_rs = 7;
    #1;
    total++;
    if ({md_busy, pc_ld, cu_mux_s} !== 3'b110) begin
      bad++;
      $display("FAIL md_add_nostall got=%b exp=110", {md_busy, pc_ld, cu_mux_s});
    end
    step();
    clear_inputs();
    id_is_mfhilo = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({md_busy, pc_ld, cu_mux_s} !== 3'b101) begin
        bad++;
        $display("FAIL md_mfhi_stall cyc=%0d got=%b exp=101", i, {md_busy, pc_ld, cu_mux_s});
      end
      if (cu_mux_s) stalls++;
      step();
    end
    total++;
    if ({md_busy, pc_ld, cu_mux_s} !== 3'b010) begin
      bad++;
      $display("FAIL md_drain got=%b exp=010", {md_busy, pc_ld, cu_mux_s});
    end
    total++;
    if (stalls !== 3) begin
      bad++;
      $display("FAIL md_stall_count got=%0d exp=3", stalls);
    end
    step();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    id_is_md = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({md_busy, pc_ld, cu_mux_s} !== 3'b101) begin
        bad++;
        $display("FAIL b2b_busy cyc=%0d got=%b exp=101", i, {md_busy, pc_ld, cu_mux_s});
      end
      step();
    end
    total++;
    if ({md_busy, pc_ld, cu_mux_s} !== 3'b010) begin
      bad++;
      $display("FAIL b2b_accept got=%b exp=010", {md_busy, pc_ld, cu_mux_s});
    end
    step();
    clear_inputs();
    total++;
    if (md_busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second got=%b exp=1", md_busy);
    end
    repeat (4) step();
  endtask

  task automatic test_combined();
    clear_inputs();
    id_is_md = 1;
    step();
    ex_rd = 7; ex_rf_enable = 1; ex_load_instr = 1; id_rs = 7; id_uses_rs = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({pc_ld, cu_mux_s, md_busy} !== {2'b01, i < 4}) begin
        bad++;
        $display("FAIL both_stall cyc=%0d got=%b exp=%b", i, {pc_ld, cu_mux_s, md_busy}, {2'b01, i < 4});
      end
      step();
    end
    total++;
    if (md_busy !== 1'b0) begin
      bad++;
      $display("FAIL both_no_accept got=%b exp=0", md_busy);
    end
    ex_rf_enable = 0; ex_load_instr = 0;
    #1;
    total++;
    if ({pc_ld, cu_mux_s} !== 2'b10) begin
      bad++;
      $display("FAIL both_clear got=%b exp=10", {pc_ld, cu_mux_s});
    end
    step();
    clear_inputs();
    total++;
    if (md_busy !== 1'b1) begin
      bad++;
      $display("FAIL both_accepted got=%b exp=1", md_busy);
    end
  endtask

  task automatic test_reset_mid();
    step();
    step();
    total++;
    if (md_busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy got=%b exp=1", md_busy);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    id_is_mfhilo = 1;
    #1;
    total++;
    if ({md_busy, pc_ld, cu_mux_s} !== 3'b010) begin
      bad++;
      $display("FAIL mid_abort got=%b exp=010", {md_busy, pc_ld, cu_mux_s});
    end
`ifdef HAZARD_STATS_EN
    total++;
    if (stall_cycles !== 16'd0 || bubble_md !== 16'd0) begin
      bad++;
      $display("FAIL mid_stats got=%0d/%0d exp=0/0", stall_cycles, bubble_md);
    end
`endif
    step();
    total++;
    if (md_busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_stays_idle got=%b exp=0", md_busy);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_md();
    test_back_to_back();
    test_combined();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the PPU pipeline.
- Drives the load enables of PC_Register, NPC_Register and IFID_Stage.
- Drives the select `S` of the control-signal mux; S=1 injects a NOP bundle into ID/EX.
- Generates operand-forwarding selects for ID.
- Tracks a multi-cycle HI/LO multiply/divide unit so dependent instructions stall until it drains.

Parameters:
- REG_W, 5, register-specifier width.
- MD_LATENCY, 4, cycles the mult/div unit stays busy after acceptance; legal range 1..15.
- CNT_W, 4, width of the busy counter; must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- id_rs  in  REG_W  rs of the instruction in ID.
- id_rt  in  REG_W  rt of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_md  in  1  ID instruction is mult/div (writes HI/LO).
- id_is_mfhilo  in  1  ID instruction reads HI or LO.
- ex_rd  in  REG_W  destination register in EX.
- ex_rf_enable  in  1  EX instruction writes the register file.
- ex_load_instr  in  1  EX instruction is a load.
- mem_rd  in  REG_W  destination register in MEM.
- mem_rf_enable  in  1  MEM instruction writes the register file.
- wb_rd  in  REG_W  destination register in WB.
- wb_rf_enable  in  1  WB instruction writes the register file.
- pc_ld  out  1  PC_Register load enable.
- npc_ld  out  1  NPC_Register load enable.
- ifid_ld  out  1  IFID_Stage load enable.
- cu_mux_s  out  1  control mux select; 1 = NOP.
- fwd_a_sel  out  2  rs source: 00 RF, 01 EX, 10 MEM, 11 WB.
- fwd_b_sel  out  2  rt source, same encoding.
- md_busy  out  1  mult/div unit occupied.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state <= RUN, counter <= 0.
  - While reset is low: pc_ld=npc_ld=ifid_ld=0, cu_mux_s=1, fwd_*=00, md_busy=0.
- Forwarding is combinational, priority EX > MEM > WB:
  - A source matches a stage when that stage's rf_enable is 1 and its rd equals the source register.
  - Register 0 is never forwarded (select 00).
  - EX match on a load is not forwarded; it is handled as a load-use stall.
  - Unused sources (id_uses_*==0) report 00.
- load_use = ex_load_instr & ex_rf_enable & (ex_rd != 0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- md_hazard = (counter != 0) & (id_is_md | id_is_mfhilo).
- stall = load_use | md_hazard.
  - On stall, in the same cycle: pc_ld=npc_ld=ifid_ld=0 and cu_mux_s=1 (one bubble per stalled cycle).
  - Otherwise all loads are 1 and cu_mux_s=0.
- Load-use lasts exactly one cycle. On the next cycle the load is in MEM and forwarding selects 10.
- FSM RUN -> MD_BUSY:
  - In RUN, id_is_md & !stall accepts the op: counter <= MD_LATENCY, state <= MD_BUSY.
  - In MD_BUSY, counter decrements every cycle; at counter==1 the next state is RUN with counter 0.
  - md_busy = (counter != 0).
  - A new mult/div is accepted in the first cycle counter==0, never earlier.
- Simultaneous load_use and md_hazard: a single stall; id_is_md is not accepted while stalled.
- Non-HI/LO instructions never stall on md_busy.
- A reset asserted during MD_BUSY aborts the op; the counter is cleared.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds outputs stall_cycles[15:0] and bubble_md[15:0].
  - stall_cycles counts every stall cycle.
  - bubble_md counts cycles where md_hazard & !load_use.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ppu_pkg:
  - REG_W.
  - FWD_RF/FWD_EX/FWD_MEM/FWD_WB encodings.
  - State encodings ST_RUN/ST_MD_BUSY.
  - NOP-select constant.
- One sub-module, md_busy_tracker, holds the counter, FSM and md_busy.
- Forwarding and stall logic stay in the top level.

Test Plan:
- Reset low 3 cycles -> loads 0, cu_mux_s=1, md_busy=0; release -> loads 1, cu_mux_s=0.
- EX: load r5 (rf_en=1); ID: uses rs=5 -> one cycle of loads=0/cu_mux_s=1; next cycle (r5 in MEM) fwd_a_sel=10, no stall.
- EX writes r3 (non-load), MEM writes r3, ID rt=3 -> fwd_b_sel=01. Same with ex_rd=0 / mem_rd=0 -> fwd_b_sel=00.
- id_is_md accepted with MD_LATENCY=4 -> md_busy 1 for exactly 4 cycles. mfhi presented cycle+1 -> stalls 3 cycles, proceeds on counter==0. An add in that window -> no stall.
- Load-use and md_hazard together -> single bubble per cycle; id_is_md accepted only once both clear.
- Reset pulled low mid-MD_BUSY (counter=2) -> next cycle md_busy=0. With HAZARD_STATS_EN, counters also read 0.
